// File: rtl/cdc_hs_tx.sv
// Source half of a 4-phase req/ack bus synchronizer: holds data_o steady until ack rises and falls.
// Optional handshake watchdog driving err_o is built only when CDC_HS_TIMEOUT_EN is defined.
module cdc_hs_tx #(
    parameter int DATA_WIDTH      = 8,
    parameter int ACK_SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  req_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    // state | meaning
    // IDLE  | ready for a word, req_o low, last word still held on data_o
    // REQ   | req_o high, waiting for synchronized ack to rise
    // DROP  | req_o low, waiting for synchronized ack to fall
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    if (ACK_SYNC_STAGES < 2) begin : g_bad_stages
        $error("cdc_hs_tx: ACK_SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cdc_hs_tx: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                     state;
    logic [ACK_SYNC_STAGES-1:0] ack_sync;
    logic                       ack_s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync[ACK_SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            req_o    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            data_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // a stale high ack_s is ignored here; REQ simply exits on its first cycle
                    if (in_valid) begin
                        data_o   <= in_data;
                        req_o    <= 1'b1;
                        in_ready <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        req_o <= 1'b0;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (!ack_s) begin
                        in_ready <= 1'b1;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    req_o    <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_next;
    logic             state_chg;

    always_comb begin
        state_chg = 1'b0;
        case (state)
            IDLE:    state_chg = in_valid;
            REQ:     state_chg = ack_s;
            DROP:    state_chg = !ack_s;
            default: state_chg = 1'b1;
        endcase
    end

    assign wd_next = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err_o  <= 1'b0;
        end else if (state_chg || state == IDLE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_next;
            // watchdog only flags; the handshake keeps waiting for the destination
            if (wd_next >= CNT_LIMIT) begin
                err_o <= 1'b1;
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
